// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4: four-way request arbiter with a registered output slot.
// Ports: clk, rst (sync, active-high), req[3:0], in_0..in_3, prio_mode,
//   out_ready in; out_valid, out_data, out_sel, ack[3:0], xfer_count out.
//   prio_mode 0 = round-robin after last winner, 1 = fixed (req[3] top).

module mux_arbiter_4 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              prio_mode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic [3:0]        ack,
  output logic [7:0]        xfer_count
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        last;
  logic [1:0]        win;
  logic [1:0]        rr_win;
  logic [1:0]        fp_win;
  logic [1:0]        rr_idx;
  logic              rr_found;
  logic              arb;
  logic              fire;
  logic [DATA_W-1:0] win_data;

  // The slot may be refilled when empty or when it drains this cycle.
  assign fire = (state == BUSY) && out_ready;
  assign arb  = (state == IDLE) || out_ready;

  // Round-robin: scan last+1, last+2, ... wrapping mod 4; the
  // fourth step lands back on last itself.
  always_comb begin
    rr_win   = 2'd0;
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last + 2'(k);
      if (!rr_found && req[rr_idx]) begin
        rr_win   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    fp_win = 2'd0;
    priority case (1'b1)
      req[3]:  fp_win = 2'd3;
      req[2]:  fp_win = 2'd2;
      req[1]:  fp_win = 2'd1;
      default: fp_win = 2'd0;
    endcase
  end

  assign win = prio_mode ? fp_win : rr_win;

  always_comb begin
    win_data = '0;
    unique case (win)
      2'd0: win_data = in_0;
      2'd1: win_data = in_1;
      2'd2: win_data = in_2;
      2'd3: win_data = in_3;
      default: win_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'd0;
      ack        <= 4'b0000;
      xfer_count <= 8'd0;
      last       <= 2'd3;
    end else begin
      ack <= 4'b0000;
      if (fire) begin
        xfer_count <= xfer_count + 8'd1;
      end
      if (arb) begin
        if (req != 4'b0000) begin
          state     <= BUSY;
          out_valid <= 1'b1;
          out_data  <= win_data;
          out_sel   <= win;
          ack       <= 4'b0001 << win;
          last      <= win;
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter_4.sv
// tb_mux_arbiter_4: scoreboard bench for mux_arbiter_4.
// Driver pushes per-cycle expectations; monitor pops and compares.

module tb_mux_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] in_0, in_1, in_2, in_3;
  logic       prio_mode;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [3:0] ack;
  logic [7:0] xfer_count;

  mux_arbiter_4 #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .prio_mode(prio_mode), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .ack(ack), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [1:0] sel;
    logic [3:0] ack;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   done   = 0;

  // Reference state, held as plain integers.
  int   m_valid, m_data, m_sel, m_last, m_cnt;
  string cur_tag;

  function automatic int pick(input int r, input int pm,
                              input int lst);
    int w;
    w = -1;
    if (pm != 0) begin
      for (int i = 3; i >= 0; i--)
        if (w < 0 && r[i]) w = i;
    end else begin
      for (int k = 1; k <= 4; k++)
        if (w < 0 && r[(lst + k) % 4]) w = (lst + k) % 4;
    end
    return w;
  endfunction

  // Apply one cycle of inputs and predict the state after the edge.
  task automatic step(input bit r, input logic [3:0] rq,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input bit pm, input bit rdy);
    exp_t e;
    int   w, a;
    int   dv[4];
    @(negedge clk);
    #1;
    rst = r; req = rq; prio_mode = pm; out_ready = rdy;
    in_0 = d0; in_1 = d1; in_2 = d2; in_3 = d3;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    a = 0;
    if (r) begin
      m_valid = 0; m_data = 0; m_sel = 0;
      m_cnt = 0; m_last = 3;
    end else begin
      if (m_valid != 0 && rdy) m_cnt = (m_cnt + 1) % 256;
      if (m_valid == 0 || rdy) begin
        w = pick(int'(rq), int'(pm), m_last);
        if (w >= 0) begin
          m_valid = 1; m_data = dv[w]; m_sel = w;
          m_last = w; a = 1 << w;
        end else begin
          m_valid = 0;
        end
      end
    end
    e.valid = m_valid[0];
    e.data  = m_data[7:0];
    e.sel   = m_sel[1:0];
    e.ack   = a[3:0];
    e.cnt   = m_cnt[7:0];
    e.tag   = cur_tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (out_valid !== e.valid || out_data !== e.data ||
            out_sel !== e.sel || ack !== e.ack ||
            xfer_count !== e.cnt) begin
          n_miss++;
          $display("FAIL %s: got v=%b d=%h s=%0d a=%b c=%0d exp v=%b d=%h s=%0d a=%b c=%0d",
                   e.tag, out_valid, out_data, out_sel, ack,
                   xfer_count, e.valid, e.data, e.sel, e.ack, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    rst = 1; req = 0; prio_mode = 0; out_ready = 0;
    in_0 = 0; in_1 = 0; in_2 = 0; in_3 = 0;
    m_valid = 0; m_data = 0; m_sel = 0; m_last = 3; m_cnt = 0;

    cur_tag = "reset";
    step(1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1);
    step(1, 4'b0000, 0, 0, 0, 0, 0, 1);

    cur_tag = "single";
    step(0, 4'b0100, 0, 0, 8'h5A, 0, 0, 1);
    step(0, 4'b0000, 0, 0, 0, 0, 0, 1);
    step(0, 4'b0000, 0, 0, 0, 0, 0, 1);

    cur_tag = "rr_fair";
    for (int i = 0; i < 6; i++)
      step(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 0, 1);
    step(0, 4'b0000, 0, 0, 0, 0, 0, 1);

    cur_tag = "fixed";
    for (int i = 0; i < 4; i++)
      step(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 1);
    for (int i = 0; i < 4; i++)
      step(0, 4'b0011, 8'h10, 8'h11, 8'h12, 8'h13, 1, 1);
    step(0, 4'b0000, 0, 0, 0, 0, 1, 1);

    cur_tag = "backpressure";
    step(0, 4'b0010, 0, 8'hA5, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(0, 4'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom), 0);
    step(0, 4'b0000, 0, 0, 0, 0, 0, 1);
    step(0, 4'b0000, 0, 0, 0, 0, 0, 1);

    cur_tag = "wrap";
    for (int i = 0; i < 260; i++)
      step(0, 4'b1111, 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3),
           0, 1);

    cur_tag = "rst_busy";
    step(0, 4'b1111, 1, 2, 3, 4, 0, 0);
    step(1, 4'b1111, 1, 2, 3, 4, 0, 1);
    step(0, 4'b1111, 1, 2, 3, 4, 0, 1);
    step(0, 4'b1111, 1, 2, 3, 4, 0, 1);

    cur_tag = "random";
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) == 0),
           4'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0) ? ~prio_mode : prio_mode,
           1'($urandom));

    for (int i = 0; i < 4; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
